// File: rtl/bin_bcd_display_conv.sv
// Binary to display-digit converter for the calculator screen.
//
// Decimal mode converts `valor` with shift-add-3 (double dabble), one bit per
// clock, so a conversion takes WIDTH cycles. Hex mode copies the value's
// nibbles straight onto the digit bus after one cycle. `numeros` is only
// written when a conversion finishes, so the screen never shows a partially
// converted value.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset, dominant
//   start     conversion request, sampled only when idle
//   hex_mode  1 = hex pass-through, 0 = decimal conversion (sampled with start)
//   valor     unsigned binary value (sampled with start)
//   numeros   digit bus, digit k at [4k+3:4k], digit 0 least significant
//   busy      high while a conversion is in progress
//   done      one-cycle pulse in the cycle `numeros` has just been updated
module bin_bcd_display_conv #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hex_mode,
  input  logic [WIDTH-1:0]      valor,
  output logic [4*DIGITS-1:0]   numeros,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StHexld} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  bin_q;
  logic [BcdW-1:0]   bcd_q;
  logic [CntW-1:0]   cnt_q;

  logic [BcdW-1:0]   bcd_adj;
  logic [BcdW-1:0]   bcd_shift;

  // Add-3 correction on every digit in parallel, then shift in the next
  // binary MSB. A corrected digit is at most 12, so no carry between digits.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
    bcd_shift = {bcd_adj[BcdW-2:0], bin_q[WIDTH-1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      numeros <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            bin_q   <= valor;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= hex_mode ? StHexld : StShift;
          end
        end
        StShift: begin
          bcd_q <= bcd_shift;
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q + 1'b1;
          // The final iteration's result goes straight to the display.
          if (cnt_q == LastCnt) begin
            numeros <= bcd_shift;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        StHexld: begin
          numeros <= BcdW'(bin_q);
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
